// File: rtl/bfm_ahbl_slave_mem.sv
// AHB-Lite memory slave BFM: word-organised scratch memory with fixed wait states,
// two-cycle ERROR responses for an address window or illegal accesses, and byte-lane writes.
module bfm_ahbl_slave_mem #(
  parameter int          AWIDTH      = 10,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ERR_LO      = 32'hFFFF_FFFF,
  parameter logic [31:0] ERR_HI      = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESETN,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HMASTLOCK,
  input  logic [31:0] HWDATA,
  input  logic        HREADYIN,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam logic [3:0]  WS       = 4'(WAIT_STATES);
  localparam bit          WIN_EN   = (ERR_LO <= ERR_HI);
  localparam logic [31:0] WIN_SPAN = ERR_HI - ERR_LO;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [3:0]         r_cnt;
  logic               r_pend;
  logic               r_write;
  logic [AWIDTH-1:0]  r_idx;
  logic [1:0]         r_size;
  logic [1:0]         r_lane;
  logic [31:0]        r_mem [2**AWIDTH];

  logic        w_accept;
  logic [31:0] w_off;
  logic        w_inWin;
  logic        w_sizeErr;
  logic        w_err;
  logic        w_ready;
  logic        w_dataDone;
  logic [3:0]  w_be;
  logic        w_unused;

  assign w_unused  = ^{HBURST, HPROT, HMASTLOCK};
  assign w_accept  = HSEL & HREADYIN & HTRANS[1];
  // Unsigned offset compare covers the inclusive window without wrap concerns.
  assign w_off     = HADDR - ERR_LO;
  assign w_inWin   = WIN_EN && (w_off <= WIN_SPAN);
  assign w_sizeErr = (HSIZE > 3'd2) ||
                     ((HSIZE == 3'd1) && HADDR[0]) ||
                     ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
  assign w_err     = w_inWin | w_sizeErr;

  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_pend  <= 1'b0;
      r_write <= 1'b0;
      r_idx   <= '0;
      r_size  <= 2'd0;
      r_lane  <= 2'd0;
    end else begin
      r_state <= w_next;
      if (w_ready) begin
        r_pend <= w_accept & ~w_err;
        r_cnt  <= WS;
        if (w_accept) begin
          r_write <= HWRITE;
          r_idx   <= HADDR[AWIDTH+1:2];
          r_size  <= HSIZE[1:0];
          r_lane  <= HADDR[1:0];
        end
      end else if (r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_ERR1: w_next = S_ERR2;
      default: begin
        if (w_ready) begin
          if (w_accept) begin
            if (w_err)             w_next = S_ERR1;
            else if (WS != 4'd0)   w_next = S_WAIT;
            else                   w_next = S_IDLE;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    w_ready = 1'b1;
    HRESP   = 1'b0;
    case (r_state)
      S_WAIT: w_ready = (r_cnt == 4'd0);
      S_ERR1: begin
        w_ready = 1'b0;
        HRESP   = 1'b1;
      end
      S_ERR2: HRESP = 1'b1;
      default: ;
    endcase
  end

  assign HREADYOUT  = w_ready;
  assign w_dataDone = w_ready & r_pend;
  assign HRDATA     = (w_dataDone && !r_write) ? r_mem[r_idx] : 32'h0;

  always_comb begin
    w_be = 4'b0000;
    case (r_size)
      2'd0:    w_be = 4'b0001 << r_lane;
      2'd1:    w_be = r_lane[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  // Memory is deliberately outside the reset domain; reset only stops an in-flight commit.
  always_ff @(posedge HCLK) begin
    if (HRESETN && w_dataDone && r_write) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[r_idx][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_bfm_ahbl_slave_mem.sv
// Bench for bfm_ahbl_slave_mem: two instances (zero-wait with error window, two-wait) behind a
// small HREADY mux, driven by a pipelined master task and checked by a queue-based monitor.
module tb_bfm_ahbl_slave_mem;

  localparam int WS0 = 0;
  localparam int WS1 = 2;

  logic        HCLK = 1'b0;
  logic        HRESETN;
  logic [1:0]  hsel;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [1:0]  readyOut;
  logic [1:0]  respOut;
  logic [31:0] rdataOut [2];
  logic        dsel;
  logic        hready;

  always #5 HCLK = ~HCLK;

  assign hready = dsel ? readyOut[1] : readyOut[0];

  always @(posedge HCLK) begin
    if (!HRESETN)    dsel <= 1'b0;
    else if (hready) dsel <= hsel[1];
  end

  bfm_ahbl_slave_mem #(.AWIDTH(10), .WAIT_STATES(WS0), .ERR_LO(32'h100), .ERR_HI(32'h1FF)) u0 (
    .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(hsel[0]), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(3'b000), .HPROT(4'b0011), .HMASTLOCK(1'b0),
    .HWDATA(HWDATA), .HREADYIN(hready), .HREADYOUT(readyOut[0]), .HRESP(respOut[0]),
    .HRDATA(rdataOut[0]));

  bfm_ahbl_slave_mem #(.AWIDTH(10), .WAIT_STATES(WS1)) u1 (
    .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(hsel[1]), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(3'b000), .HPROT(4'b0011), .HMASTLOCK(1'b0),
    .HWDATA(HWDATA), .HREADYIN(hready), .HREADYOUT(readyOut[1]), .HRESP(respOut[1]),
    .HRDATA(rdataOut[1]));

  typedef struct packed {
    logic        slv;
    logic        err;
    logic        rd;
    logic [31:0] data;
  } exp_t;

  exp_t        expQ [$];
  logic [31:0] model [2][1024];
  logic [31:0] nextWdata;
  int          checkCount = 0;
  int          passCount  = 0;

  function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endfunction

  // Reference rules: window only on slave 0, natural alignment for halfword/word, size <= word.
  function automatic bit isErr(input int slv, input logic [31:0] addr, input logic [2:0] size);
    bit inWin = (slv == 0) && (addr >= 32'h100) && (addr <= 32'h1FF);
    return inWin || (size > 3'd2) || (size == 3'd1 && addr[0]) ||
           (size == 3'd2 && addr[1:0] != 2'b00);
  endfunction

  task automatic applyStimulus(input int slv, input bit sel, input logic [1:0] trans, input bit wr,
                               input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
    exp_t        e;
    int          idx;
    int          n;
    logic [31:0] word;
    hsel   = {sel && slv == 1, sel && slv == 0};
    HTRANS = trans;
    HWRITE = wr;
    HADDR  = addr;
    HSIZE  = size;
    HWDATA = nextWdata;
    if (sel && trans[1]) begin
      idx    = int'(addr >> 2) % 1024;
      e.slv  = (slv == 1);
      e.err  = isErr(slv, addr, size);
      e.rd   = !wr;
      e.data = model[slv][idx];
      if (wr && !e.err) begin
        word = model[slv][idx];
        for (int b = 0; b < (1 << size); b++) begin
          int lane = int'(addr[1:0]) + b;
          word[8*lane +: 8] = wdata[8*lane +: 8];
        end
        model[slv][idx] = word;
      end
      expQ.push_back(e);
    end
    n = 0;
    do begin
      @(negedge HCLK);
      n++;
    end while (!hready && n < 64);
    if (!hready) begin
      checkCount++;
      $display("[TB] FAIL bus timeout: HREADY still %b after %0d cycles, expected 1", hready, n);
    end
    @(posedge HCLK);
    #1;
    nextWdata = wdata;
  endtask

  task automatic applyIdle();
    applyStimulus(0, 1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 32'h0);
  endtask

  // Monitor: tracks the data phase opened by each accepted address phase and checks every cycle.
  exp_t cur;
  bit   active = 0;
  int   cyc;

  always @(negedge HCLK) begin
    logic        eR;
    logic        eP;
    logic [31:0] eD;
    bit          chkD;
    bit          last;
    int          ws;
    if (!HRESETN) begin
      active = 0;
    end else begin
      eR = 1'b1; eP = 1'b0; eD = 32'h0; chkD = 1; last = 0;
      if (active) begin
        cyc++;
        ws = cur.slv ? WS1 : WS0;
        if (cur.err) begin
          eP   = 1'b1;
          eR   = (cyc >= 2);
          last = (cyc >= 2);
        end else begin
          eR   = (cyc > ws);
          last = (cyc > ws);
          if (last) begin
            if (cur.rd) eD = cur.data;
            else        chkD = 0;
          end
        end
      end
      for (int s = 0; s < 2; s++) begin
        if (active && s == int'(cur.slv)) begin
          checkOutput($sformatf("s%0d ready cyc%0d", s, cyc), 32'(readyOut[s]), 32'(eR));
          checkOutput($sformatf("s%0d resp cyc%0d", s, cyc), 32'(respOut[s]), 32'(eP));
          if (chkD) checkOutput($sformatf("s%0d rdata cyc%0d", s, cyc), rdataOut[s], eD);
        end else begin
          checkOutput($sformatf("s%0d idle ready", s), 32'(readyOut[s]), 32'd1);
          checkOutput($sformatf("s%0d idle resp", s), 32'(respOut[s]), 32'd0);
          checkOutput($sformatf("s%0d idle rdata", s), rdataOut[s], 32'h0);
        end
      end
      if (last) active = 0;
      if (hready && hsel != 2'b00 && HTRANS[1]) begin
        if (expQ.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL scoreboard: accepted transfer with 0 expectations queued, expected 1");
        end else begin
          cur    = expQ.pop_front();
          active = 1;
          cyc    = 0;
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  sz;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 1024; i++) model[s][i] = 32'h0;
    nextWdata = 32'h0;
    hsel = 2'b00; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'h0; HSIZE = 3'd0; HWDATA = 32'h0;
    HRESETN = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    HRESETN = 1'b1;
    @(negedge HCLK);
    for (int s = 0; s < 2; s++) begin
      checkOutput($sformatf("reset s%0d ready", s), 32'(readyOut[s]), 32'd1);
      checkOutput($sformatf("reset s%0d resp", s), 32'(respOut[s]), 32'd0);
      checkOutput($sformatf("reset s%0d rdata", s), rdataOut[s], 32'h0);
    end
    @(posedge HCLK);
    #1;

    $display("[TB] back-to-back zero-wait write/read");
    applyStimulus(0, 1, 2'b10, 1, 32'h10, 3'd2, 32'hDEADBEEF);
    applyStimulus(0, 1, 2'b10, 0, 32'h10, 3'd2, 32'h0);
    applyIdle();

    $display("[TB] two wait states");
    applyStimulus(1, 1, 2'b10, 1, 32'h0, 3'd2, 32'h5A5AC3C3);
    applyStimulus(1, 1, 2'b10, 0, 32'h0, 3'd2, 32'h0);
    applyIdle();

    $display("[TB] byte and halfword lanes");
    applyStimulus(0, 1, 2'b10, 1, 32'h20, 3'd0, {4{8'h11}});
    applyStimulus(0, 1, 2'b11, 1, 32'h21, 3'd0, {4{8'h22}});
    applyStimulus(0, 1, 2'b11, 1, 32'h22, 3'd0, {4{8'h33}});
    applyStimulus(0, 1, 2'b11, 1, 32'h23, 3'd0, {4{8'h44}});
    applyStimulus(0, 1, 2'b10, 0, 32'h20, 3'd2, 32'h0);
    applyStimulus(0, 1, 2'b10, 1, 32'h22, 3'd1, {2{16'hAABB}});
    applyStimulus(0, 1, 2'b10, 0, 32'h20, 3'd2, 32'h0);
    applyIdle();

    $display("[TB] error window, illegal sizes, alignment");
    applyStimulus(0, 1, 2'b10, 1, 32'h104, 3'd2, 32'h12345678);
    applyStimulus(0, 1, 2'b10, 0, 32'h104, 3'd2, 32'h0);
    applyStimulus(0, 1, 2'b10, 0, 32'h1104, 3'd2, 32'h0);
    applyStimulus(0, 1, 2'b10, 1, 32'h02, 3'd2, 32'hFFFFFFFF);
    applyStimulus(0, 1, 2'b10, 1, 32'h40, 3'd3, 32'hFFFFFFFF);
    applyStimulus(0, 1, 2'b10, 1, 32'h02, 3'd1, {2{16'h1234}});
    applyStimulus(0, 1, 2'b10, 0, 32'h00, 3'd2, 32'h0);
    applyIdle();

    $display("[TB] reset during write wait states");
    hsel = 2'b10; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h8; HSIZE = 3'd2; HWDATA = nextWdata;
    expQ.push_back('{slv: 1'b1, err: 1'b0, rd: 1'b0, data: 32'h0});
    @(negedge HCLK);
    @(posedge HCLK);
    #1;
    hsel = 2'b00; HTRANS = 2'b00; HWDATA = 32'hCAFEF00D; HRESETN = 1'b0;
    @(posedge HCLK);
    #1;
    HRESETN = 1'b1;
    nextWdata = 32'h0;
    @(negedge HCLK);
    checkOutput("post-reset s1 ready", 32'(readyOut[1]), 32'd1);
    checkOutput("post-reset s1 resp", 32'(respOut[1]), 32'd0);
    checkOutput("post-reset s1 rdata", rdataOut[1], 32'h0);
    @(posedge HCLK);
    #1;
    applyStimulus(1, 1, 2'b10, 0, 32'h8, 3'd2, 32'h0);
    applyIdle();

    $display("[TB] IDLE, BUSY and unselected transfers");
    applyStimulus(0, 1, 2'b00, 1, 32'h10, 3'd2, 32'h0BAD0BAD);
    applyStimulus(0, 1, 2'b01, 1, 32'h10, 3'd2, 32'h0BAD0BAD);
    applyStimulus(0, 0, 2'b10, 1, 32'h10, 3'd2, 32'h0BAD0BAD);
    applyStimulus(0, 1, 2'b10, 0, 32'h10, 3'd2, 32'h0);
    applyIdle();

    $display("[TB] randomized traffic");
    for (int t = 0; t < 300; t++) begin
      a  = $urandom % 32'h400;
      if ($urandom % 4 == 0) a = a | 32'h1000;
      sz = ($urandom % 8 == 0) ? 3'd3 : 3'($urandom % 3);
      if ($urandom % 4 != 0 && sz < 3'd3) a = a & ~((32'd1 << sz) - 32'd1);
      applyStimulus(int'($urandom % 2), ($urandom % 8) != 0, 2'($urandom % 4), 1'($urandom % 2),
                    a, sz, $urandom);
    end
    repeat (4) applyIdle();

    checkOutput("queue drained", 32'(expQ.size()), 32'd0);
    checkOutput("monitor settled", 32'(active), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
